// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALUControl code constants, execution FSM state
//               encoding and default datapath widths. Also imported by the
//               ALU decoder so both sides agree on the code values.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_DEFAULT_WIDTH   = 32;
    localparam int c_DEFAULT_SHAMT_W = 5;

    // ALUControl codes
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_SLL  = 4'b0100;
    localparam logic [3:0] c_ALU_SLT  = 4'b0101;
    localparam logic [3:0] c_ALU_XOR  = 4'b0110;
    localparam logic [3:0] c_ALU_SRL  = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU = 4'b1000;
    localparam logic [3:0] c_ALU_SRA  = 4'b1111;

    // Execution FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the three codes that go through the bit-serial shifter
    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == c_ALU_SLL) || (ctrl == c_ALU_SRL) || (ctrl == c_ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_if
// Description : Operation/result handshake bundle for alu_exec_unit.
//               master : issuing side (drives in_valid, alu_ctrl, src_a,
//                        src_b, flush, out_ready)
//               slave  : execution unit (drives in_ready, out_valid,
//                        result and the zero/neg/carry/overflow/illegal flags)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, flush, out_ready,
        input  in_ready, out_valid, result, zero, neg, carry, overflow, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, flush, out_ready,
        output in_ready, out_valid, result, zero, neg, carry, overflow, illegal
    );

endinterface
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Single-cycle arithmetic / logic / compare block.
//               Ports: i_ctrl (ALUControl), i_a, i_b (operands),
//                      o_result, o_zero, o_neg, o_carry, o_overflow, o_illegal.
//               Shift codes pass i_a through unchanged: that is the correct
//               answer for a zero shift amount, and non-zero shifts are done
//               serially by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic [3:0]       i_ctrl,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_result,
    output logic                  o_zero,
    output logic                  o_neg,
    output logic                  o_carry,
    output logic                  o_overflow,
    output logic                  o_illegal
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_a_msb;
    logic             w_b_msb;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = i_a - i_b;
    assign w_a_msb = i_a[WIDTH-1];
    assign w_b_msb = i_b[WIDTH-1];

    always_comb begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        o_illegal  = 1'b0;
        case (i_ctrl)
            c_ALU_ADD: begin
                o_result   = w_sum[WIDTH-1:0];
                o_carry    = w_sum[WIDTH];
                // same-sign operands producing an opposite-sign sum
                o_overflow = (w_a_msb == w_b_msb) && (w_sum[WIDTH-1] != w_a_msb);
            end
            c_ALU_SUB: begin
                o_result   = w_diff;
                // carry is "no borrow"
                o_carry    = (i_a >= i_b);
                o_overflow = (w_a_msb != w_b_msb) && (w_diff[WIDTH-1] != w_a_msb);
            end
            c_ALU_AND:  o_result = i_a & i_b;
            c_ALU_OR:   o_result = i_a | i_b;
            c_ALU_XOR:  o_result = i_a ^ i_b;
            c_ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            c_ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            c_ALU_SLL,
            c_ALU_SRL,
            c_ALU_SRA:  o_result = i_a;
            default:    o_illegal = 1'b1;
        endcase
    end

    // Illegal codes leave o_result at zero, so zero=1 / neg=0 falls out here
    assign o_zero = (o_result == '0);
    assign o_neg  = o_result[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : ALU execution unit with valid/ready handshakes. Single-cycle
//               operations complete one cycle after acceptance; shifts run
//               one bit per cycle (latency shamt+1). Results and flags are
//               held until the consumer takes them. flush aborts any
//               operation; rst overrides everything.
//               Ports: clk, rst (synchronous, active-high),
//                      bus (alu_exec_unit_if.slave): in_valid/in_ready,
//                      alu_ctrl, src_a, src_b, flush, out_valid/out_ready,
//                      result, zero, neg, carry, overflow, illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int SHAMT_W = c_DEFAULT_SHAMT_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_exec_unit_if.slave  bus
);

    // Registered state
    state_t             r_state;
    logic [3:0]         r_ctrl;
    logic [WIDTH-1:0]   r_sh;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_overflow;
    logic               r_illegal;
    logic               r_out_valid;

    // Next-state values
    state_t             w_state_next;
    logic [3:0]         w_ctrl_next;
    logic [WIDTH-1:0]   w_sh_next;
    logic [SHAMT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0]   w_result_next;
    logic               w_zero_next;
    logic               w_neg_next;
    logic               w_carry_next;
    logic               w_overflow_next;
    logic               w_illegal_next;
    logic               w_out_valid_next;

    // Single-cycle datapath outputs
    logic [WIDTH-1:0]   w_comb_result;
    logic               w_comb_zero;
    logic               w_comb_neg;
    logic               w_comb_carry;
    logic               w_comb_overflow;
    logic               w_comb_illegal;

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_sh_step;
    logic               w_accept;

    assign w_shamt  = bus.src_b[SHAMT_W-1:0];
    assign w_accept = bus.in_valid && (r_state == ST_IDLE) && !bus.flush;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .i_ctrl     (bus.alu_ctrl),
        .i_a        (bus.src_a),
        .i_b        (bus.src_b),
        .o_result   (w_comb_result),
        .o_zero     (w_comb_zero),
        .o_neg      (w_comb_neg),
        .o_carry    (w_comb_carry),
        .o_overflow (w_comb_overflow),
        .o_illegal  (w_comb_illegal)
    );

    // One-bit shift step selected by the latched code
    always_comb begin
        w_sh_step = r_sh;
        case (r_ctrl)
            c_ALU_SLL: w_sh_step = {r_sh[WIDTH-2:0], 1'b0};
            c_ALU_SRL: w_sh_step = {1'b0, r_sh[WIDTH-1:1]};
            c_ALU_SRA: w_sh_step = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
            default:   w_sh_step = r_sh;
        endcase
    end

    // Next-state and datapath-load logic
    always_comb begin
        w_state_next     = r_state;
        w_ctrl_next      = r_ctrl;
        w_sh_next        = r_sh;
        w_cnt_next       = r_cnt;
        w_result_next    = r_result;
        w_zero_next      = r_zero;
        w_neg_next       = r_neg;
        w_carry_next     = r_carry;
        w_overflow_next  = r_overflow;
        w_illegal_next   = r_illegal;
        w_out_valid_next = r_out_valid;

        if (bus.flush) begin
            // flush beats a simultaneous in_valid or out_ready
            w_state_next     = ST_IDLE;
            w_out_valid_next = 1'b0;
            w_cnt_next       = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_ctrl_next = bus.alu_ctrl;
                        if (is_shift(bus.alu_ctrl) && (w_shamt != '0)) begin
                            w_sh_next    = bus.src_a;
                            w_cnt_next   = w_shamt;
                            w_state_next = ST_SHIFT;
                        end else begin
                            w_result_next    = w_comb_result;
                            w_zero_next      = w_comb_zero;
                            w_neg_next       = w_comb_neg;
                            w_carry_next     = w_comb_carry;
                            w_overflow_next  = w_comb_overflow;
                            w_illegal_next   = w_comb_illegal;
                            w_out_valid_next = 1'b1;
                            w_state_next     = ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    w_sh_next  = w_sh_step;
                    w_cnt_next = r_cnt - SHAMT_W'(1);
                    // the step taken with one bit remaining is the last one
                    if (r_cnt == SHAMT_W'(1)) begin
                        w_result_next    = w_sh_step;
                        w_zero_next      = (w_sh_step == '0);
                        w_neg_next       = w_sh_step[WIDTH-1];
                        w_carry_next     = 1'b0;
                        w_overflow_next  = 1'b0;
                        w_illegal_next   = 1'b0;
                        w_out_valid_next = 1'b1;
                        w_state_next     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        w_out_valid_next = 1'b0;
                        w_state_next     = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next     = ST_IDLE;
                    w_out_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ctrl      <= '0;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ctrl      <= w_ctrl_next;
            r_sh        <= w_sh_next;
            r_cnt       <= w_cnt_next;
            r_result    <= w_result_next;
            r_zero      <= w_zero_next;
            r_neg       <= w_neg_next;
            r_carry     <= w_carry_next;
            r_overflow  <= w_overflow_next;
            r_illegal   <= w_illegal_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;
    assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit. Directed vector table,
//               randomized operations against a behavioural model, and
//               hand-written hold / flush / reset-mid-shift sequences.
//               Flags are compared packed as {zero,neg,carry,overflow,illegal}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
    } exp_t;

    vec_t tbl [16];

    function automatic logic [4:0] out_flags();
        return {bus.zero, bus.neg, bus.carry, bus.overflow, bus.illegal};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic on wide integers
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, s;
        longint unsigned ua, ub;
        int          sh;
        logic        cy, ov, ill;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        sh = int'(b[4:0]);
        cy = 1'b0; ov = 1'b0; ill = 1'b0;
        e.r = 32'h0;
        e.lat = 1;
        case (c)
            4'd0: begin
                e.r = a + b;
                cy  = (ua + ub) > 64'hFFFF_FFFF;
                s   = sa + sb;
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                e.r = a - b;
                cy  = (ua >= ub);
                s   = sa - sb;
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  e.r = a & b;
            4'd3:  e.r = a | b;
            4'd6:  e.r = a ^ b;
            4'd5:  e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  e.r = (ua < ub) ? 32'd1 : 32'd0;
            4'd4:  e.r = a << sh;
            4'd7:  e.r = a >> sh;
            4'd15: e.r = $unsigned($signed(a) >>> sh);
            default: ill = 1'b1;
        endcase
        if ((c == 4'd4 || c == 4'd7 || c == 4'd15) && sh != 0) e.lat = sh + 1;
        e.f = {(e.r == 32'h0), e.r[31], cy, ov, ill};
        return e;
    endfunction

    // Offer one operation and wait for its result (bounded). Leaves the
    // result pending in DONE; release() completes the output handshake.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit busy_ok);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c;
        bus.src_a    = a;
        bus.src_b    = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        bit   busy_ok;
        bit   seen;
        exp_t e;
        logic [3:0]  rc;
        logic [31:0] ra, rb;

        tbl[0]  = '{4'h1, 32'h5,        32'h7,        32'hFFFF_FFFE, 5'b01000, 1};
        tbl[1]  = '{4'h0, 32'h7FFF_FFFF, 32'h1,       32'h8000_0000, 5'b01010, 1};
        tbl[2]  = '{4'hF, 32'h8000_0000, 32'd31,      32'hFFFF_FFFF, 5'b01000, 32};
        tbl[3]  = '{4'h4, 32'h1234,     32'h0,        32'h1234,      5'b00000, 1};
        tbl[4]  = '{4'hA, 32'h5,        32'h3,        32'h0,         5'b10001, 1};
        tbl[5]  = '{4'h8, 32'h1,        32'hFFFF_FFFF, 32'h1,        5'b00000, 1};
        tbl[6]  = '{4'h0, 32'hFFFF_FFFF, 32'h1,       32'h0,         5'b10100, 1};
        tbl[7]  = '{4'h1, 32'h7,        32'h7,        32'h0,         5'b10100, 1};
        tbl[8]  = '{4'h5, 32'hFFFF_FFFF, 32'h1,       32'h1,         5'b00000, 1};
        tbl[9]  = '{4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'b00000, 1};
        tbl[10] = '{4'h7, 32'h8000_0000, 32'h4,       32'h0800_0000, 5'b00000, 5};
        tbl[11] = '{4'h4, 32'h1,        32'h21,       32'h2,         5'b00000, 2};
        tbl[12] = '{4'h1, 32'h8000_0000, 32'h1,       32'h7FFF_FFFF, 5'b00110, 1};
        tbl[13] = '{4'h3, 32'h00FF,     32'hF000,     32'hF0FF,      5'b00000, 1};
        tbl[14] = '{4'h2, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 5'b00000, 1};
        tbl[15] = '{4'h8, 32'hFFFF_FFFF, 32'h1,       32'h0,         5'b10000, 1};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.alu_ctrl = 4'h0; bus.src_a = 32'h0; bus.src_b = 32'h0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result",    64'(bus.result),    64'd0);
        chk("reset_flags",     64'(out_flags()),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready",  64'(bus.in_ready),  64'd1);

        // Directed vector table
        foreach (tbl[i]) begin
            issue(tbl[i].c, tbl[i].a, tbl[i].b, lat, busy_ok);
            chk($sformatf("vec%0d_result", i),  64'(bus.result), 64'(tbl[i].r));
            chk($sformatf("vec%0d_flags", i),   64'(out_flags()), 64'(tbl[i].f));
            chk($sformatf("vec%0d_latency", i), 64'(lat),        64'(tbl[i].lat));
            if (tbl[i].lat > 1)
                chk($sformatf("vec%0d_busy_ready", i), 64'(busy_ok), 64'd1);
            release_out();
            chk($sformatf("vec%0d_idle_ready", i), 64'(bus.in_ready), 64'd1);
        end

        // Randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom();
            rb = $urandom();
            e  = model(rc, ra, rb);
            issue(rc, ra, rb, lat, busy_ok);
            chk($sformatf("rand%0d_c%0h_result", n, rc), 64'(bus.result), 64'(e.r));
            chk($sformatf("rand%0d_c%0h_flags", n, rc),  64'(out_flags()), 64'(e.f));
            chk($sformatf("rand%0d_c%0h_latency", n, rc), 64'(lat),       64'(e.lat));
            release_out();
        end

        // Result held while consumer stalls
        issue(4'h0, 32'h7FFF_FFFF, 32'h1, lat, busy_ok);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", k),  64'(bus.out_valid), 64'd1);
            chk($sformatf("hold%0d_result", k), 64'(bus.result),    64'h8000_0000);
            chk($sformatf("hold%0d_flags", k),  64'(out_flags()),   64'(5'b01010));
        end
        release_out();
        chk("hold_release_valid", 64'(bus.out_valid), 64'd0);

        // flush with in_valid in IDLE: nothing accepted
        @(negedge clk);
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.alu_ctrl = 4'h0;
        bus.src_a = 32'h1; bus.src_b = 32'h2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        @(posedge clk); #1;
        chk("flush_idle_no_accept", 64'(bus.out_valid), 64'd0);

        // flush during the third SHIFT cycle of srl by 10
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'h7; bus.src_a = 32'hFFFF_0000; bus.src_b = 32'd10;
        @(posedge clk); #1;          // accepted; SHIFT cycle 1
        bus.in_valid = 1'b0;
        @(posedge clk); #1;          // SHIFT cycle 2
        @(posedge clk); #1;          // SHIFT cycle 3
        chk("flush_in_shift_busy", 64'(bus.in_ready), 64'd0);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_shift_idle",  64'(bus.in_ready),  64'd1);
        seen = bus.out_valid;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_shift_never_valid", 64'(seen), 64'd0);

        // rst in the middle of sra by 20 (result register nonzero beforehand)
        issue(4'h3, 32'h1, 32'h0, lat, busy_ok);
        release_out();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'hF; bus.src_a = 32'h8000_0000; bus.src_b = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_shift_valid",  64'(bus.out_valid), 64'd0);
        chk("rst_shift_result", 64'(bus.result),    64'd0);
        chk("rst_shift_flags",  64'(out_flags()),   64'd0);
        @(posedge clk); #1;
        chk("rst_release_ready", 64'(bus.in_ready), 64'd1);
        seen = bus.out_valid;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rst_shift_never_valid", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-007 SHALL have port alu_ctrl  input  4  ALUControl code from the ALU decoder.
REQ-008 SHALL have port src_a  input  WIDTH  operand A.
REQ-009 SHALL have port src_b  input  WIDTH  operand B; bits [SHAMT_W-1:0] are the shift amount for shifts.
REQ-010 SHALL have port flush  input  1  abort any in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  WIDTH  operation result.
REQ-014 SHALL have ports zero, neg, carry, overflow  output  1 each  result flags.
REQ-015 SHALL have port illegal  output  1  alu_ctrl was not a defined code.

Function
REQ-016 SHALL decode codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt (signed), 0110 xor, 0111 srl, 1000 sltu, 1111 sra; all others illegal.
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-018 SHALL accept an operation when in_valid & in_ready & !flush, latching alu_ctrl, src_a, src_b.
REQ-019 SHALL, for non-shift and illegal codes, go IDLE->DONE with out_valid asserted the cycle after acceptance (latency 1).
REQ-020 SHALL, for shifts with shamt=0, go IDLE->DONE with result=src_a, latency 1.
REQ-021 SHALL, for shifts with shamt=N>0, go IDLE->SHIFT, shift one bit per cycle for N cycles, then DONE; out_valid latency N+1 cycles.
REQ-022 SHALL fill zeros for sll/srl and replicate bit WIDTH-1 for sra.
REQ-023 SHALL hold result and flags stable in DONE until out_valid & out_ready, then return to IDLE next cycle; no acceptance occurs in the same cycle as output handshake.
REQ-024 SHALL compute add/sub modulo 2^WIDTH; carry = carry-out for add, carry = 1 iff src_a >= src_b unsigned for sub; overflow = signed overflow; carry=overflow=0 for all other codes.
REQ-025 SHALL set slt/sltu result to 1 or 0 zero-extended to WIDTH.
REQ-026 SHALL set zero = (result==0), neg = result[WIDTH-1] for every defined code.
REQ-027 SHALL, for illegal codes, output result=0, illegal=1, zero=1, other flags 0.
REQ-028 SHALL, on flush in any state, enter IDLE next cycle with out_valid=0; flush wins over simultaneous in_valid and out_ready.

Reset
REQ-029 SHALL on rst enter IDLE and clear out_valid, result, zero, neg, carry, overflow, illegal and shift counter to 0 next edge.
REQ-030 SHALL let rst override flush and any in-flight operation, including mid-SHIFT.
REQ-031 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place ALUControl code constants, FSM state encoding and default WIDTH in shared package alu_pkg, also used by the ALU decoder.
REQ-033 SHALL isolate single-cycle arithmetic/logic/compare into one combinational sub-module alu_comb; shifting and FSM stay in alu_exec_unit.

Verification
REQ-034 SHALL cover: sub 5-7 -> result 0xFFFFFFFE, neg=1, carry=0, overflow=0, out_valid 1 cycle after accept.
REQ-035 SHALL cover: add 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, carry=0, neg=1.
REQ-036 SHALL cover: sra 0x80000000 by 31 -> result 0xFFFFFFFF, out_valid 32 cycles after accept, in_ready=0 throughout.
REQ-037 SHALL cover: sll shamt 0 on 0x1234 -> result 0x1234 latency 1; illegal code 1010 -> result 0, illegal=1, zero=1.
REQ-038 SHALL cover: out_ready held low 5 cycles in DONE -> result/flags stable; flush at SHIFT cycle 3 of srl by 10 -> IDLE next cycle, out_valid never asserted.
REQ-039 SHALL cover: rst mid-SHIFT -> all outputs 0, in_ready=1 cycle after rst release; sltu 1 vs 0xFFFFFFFF -> result 1.
